// File: rtl/eth_udp_pkg.sv
// Shared definitions for the UDP transmit path: FSM state encoding,
// sequence-header size and the largest UDP payload that fits an
// untagged 1500-byte Ethernet MTU.
package eth_udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  localparam int SEQ_HDR_BYTES   = 4;
  localparam int UDP_MAX_PAYLOAD = 1472;

endpackage

// File: rtl/udp_tx_fifo.sv
// Synchronous byte FIFO for the UDP transmit packetizer.
// Read data is registered: it appears the cycle after a pop and then holds.
// Push and pop in the same cycle are both honoured.
module udp_tx_fifo
  import eth_udp_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  pop_data,
  output logic [FIFO_AW:0]   occupancy,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_OCC = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign full      = (count == DEPTH_OCC);
  assign empty     = (count == '0);
  assign occupancy = count;
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  // Storage array: written only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the depth; occupancy tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered read port (pipeline stage p1): updates only on a real pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_data <= '0;
    end else if (pop_ok) begin
      pop_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/udp_tx_packetizer.sv
// UDP transmit packetizer: buffers an application byte stream and hands
// it to the UDP transmit layer as payloads of MAX_PAYLOAD bytes, or as a
// shorter payload once a partial buffer has aged TIMEOUT_CYCLES.
// Optional build macro UDP_TX_SEQ_HDR_EN prefixes every payload with a
// 4-byte big-endian packet sequence number.
module udp_tx_packetizer
  import eth_udp_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 1024,
  parameter int FIFO_AW        = 11,
  parameter int TIMEOUT_CYCLES = 125000,
  parameter int IFG_CYCLES     = 16
) (
  input  logic        rgmii_clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        udp_send_req,
  output logic [15:0] udp_send_length,
  input  logic        udp_send_ack,
  input  logic        udp_data_rd,
  output logic [7:0]  udp_send_data,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_SEND = ST_SEND;
  localparam logic [1:0] S_GAP  = ST_GAP;

  localparam logic [FIFO_AW:0] MAX_OCC     = (FIFO_AW + 1)'(MAX_PAYLOAD);
  localparam logic [31:0]      TIMEOUT_MAX = 32'(TIMEOUT_CYCLES);
  localparam logic [15:0]      IFG_LAST    = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
`ifdef UDP_TX_SEQ_HDR_EN
  localparam logic [15:0]      HDR_LEN     = 16'(SEQ_HDR_BYTES);
`else
  localparam logic [15:0]      HDR_LEN     = 16'd0;
`endif

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]       state;
  logic [31:0]      age;
  logic [15:0]      len_q;
  logic [15:0]      down_cnt;
  logic [15:0]      gap_cnt;
  logic [15:0]      drop_q;

  logic [FIFO_AW:0] fifo_occ;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout_p1;
  logic             fifo_pop;

  logic             rd_ok;
  logic             full_hit;
  logic             timeout_hit;

  assign in_ready        = !fifo_full;
  assign udp_send_req    = (state == S_REQ);
  assign busy            = (state != S_IDLE);
  assign udp_send_length = len_q;
  assign drop_cnt        = drop_q;

  assign rd_ok       = (state == S_SEND) && udp_data_rd && (down_cnt != 16'd0);
  assign full_hit    = (fifo_occ >= MAX_OCC);
  assign timeout_hit = !fifo_empty && (TIMEOUT_CYCLES != 0) && (age == TIMEOUT_MAX);

  udp_tx_fifo #(
    .DATA_W  (8),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk       (rgmii_clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout_p1),
    .occupancy (fifo_occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef UDP_TX_SEQ_HDR_EN
  function automatic logic [7:0] hdr_byte(input logic [31:0] seq, input logic [2:0] idx);
    case (idx)
      3'd0:    return seq[31:24];
      3'd1:    return seq[23:16];
      3'd2:    return seq[15:8];
      default: return seq[7:0];
    endcase
  endfunction

  logic [31:0] seq_cnt;
  logic [31:0] seq_lat;
  logic [2:0]  hdr_idx;
  logic        in_hdr;
  logic        hdr_sel_p1;
  logic [7:0]  hdr_byte_p1;

  assign in_hdr        = (hdr_idx < 3'(SEQ_HDR_BYTES));
  assign fifo_pop      = rd_ok && !in_hdr;
  assign udp_send_data = hdr_sel_p1 ? hdr_byte_p1 : fifo_dout_p1;

  // Sequence number is captured when a payload is accepted, then its bytes
  // are served MSB first ahead of the FIFO data without popping the FIFO.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      seq_cnt     <= '0;
      seq_lat     <= '0;
      hdr_idx     <= '0;
      hdr_sel_p1  <= 1'b0;
      hdr_byte_p1 <= '0;
    end else begin
      if (state == S_REQ && udp_send_ack) begin
        seq_lat <= seq_cnt;
        seq_cnt <= seq_cnt + 32'd1;
        hdr_idx <= '0;
      end else if (rd_ok) begin
        if (in_hdr) begin
          hdr_byte_p1 <= hdr_byte(seq_lat, hdr_idx);
          hdr_sel_p1  <= 1'b1;
          hdr_idx     <= hdr_idx + 3'd1;
        end else begin
          hdr_sel_p1  <= 1'b0;
        end
      end
    end
  end
`else
  assign fifo_pop      = rd_ok;
  assign udp_send_data = fifo_dout_p1;
`endif

  // Age of the oldest buffered data: runs only while idle with data waiting.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      age <= '0;
    end else if (state != S_IDLE || fifo_empty || full_hit || timeout_hit) begin
      age <= '0;
    end else if (age != TIMEOUT_MAX) begin
      age <= age + 32'd1;
    end
  end

  // Payload FSM: close a payload, request, stream bytes out, then hold off.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      down_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (full_hit) begin
            len_q <= 16'(MAX_PAYLOAD) + HDR_LEN;
            state <= S_REQ;
          end else if (timeout_hit) begin
            len_q <= 16'(fifo_occ) + HDR_LEN;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (udp_send_ack) begin
            down_cnt <= len_q;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (rd_ok) begin
            down_cnt <= down_cnt - 16'd1;
            if (down_cnt == 16'd1) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end else if (down_cnt == 16'd0) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        default: begin
          if (gap_cnt >= IFG_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Count source bytes offered while the buffer was full.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready) begin
      drop_q <= sat_inc16(drop_q);
    end
  end

endmodule
